wrr_credit_arbiter: RTL and testbench
=====================================

# wrr_credit_arbiter

Parametrised weighted round-robin arbiter with per-grant credit bursts, an ack handshake and a runtime mode select between plain and weighted round-robin. It is the next generation of the team's weighted RR arbiter. It sits between N requesting masters and a shared single-beat resource. A grantee holds the resource for up to `weight` acknowledged beats, then priority rotates to the next requester.

## Interface
Parameters:
- N, 8, number of requesters (≥2)
- W, 4, weight/credit width in bits
- IDW, $clog2(N), width of grant_id

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- request  input  N  per-requester request level; bit i = requester i
- weights  input  N*W  packed weights; weight i = weights[i*W +: W]
- mode  input  1  0 = plain RR (1 beat per grant); 1 = weighted RR
- grant_ack  input  1  resource consumed one beat from current grantee this cycle
- grant  output  N  registered one-hot grant; all-zero when idle
- grant_valid  output  1  high iff grant is non-zero
- grant_id  output  IDW  binary index of current grantee; 0 when idle
- credit_left  output  W  beats remaining in current burst; 0 when idle

## Operation
- State: IDLE or BURST; rotating pointer `ptr` (IDW bits) = highest priority index.
- Selection: first i with request[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap mod N).
- Load on selection, all registered next edge:
  - grant = onehot(i), grant_id = i, grant_valid = 1, state = BURST.
  - credit_left = (mode ? weight_i : 1); weight 0 is loaded as 1.
- weights and mode are sampled only at load; changes mid-burst have no effect until the next load.
- BURST, each cycle:
  - If grant_ack=1, decrement credit_left.
  - End of burst when (grant_ack=1 and credit_left==1) or request[grant_id]=0. A dropped request ends the burst even with credit left; an ack in that same cycle is still counted.
  - No end: hold grant/grant_id unchanged.
  - At end: ptr = grant_id+1 mod N, then arbitrate in the same cycle using the updated ptr and the current request.
    - Winner found: load it (back-to-back, no idle cycle). A sole requester is re-granted with fresh credit.
    - No winner: go to IDLE with grant=0, grant_valid=0, grant_id=0, credit_left=0.
- IDLE: arbitrate every cycle; stay IDLE while request==0.
- grant_ack in IDLE is ignored.
- Requests from non-grantees never pre-empt a burst.
- credit_left never underflows: the decrement only happens while credit_left ≥ 1 in BURST.

## Timing
- Reset (sync, active-high): next edge forces state=IDLE, ptr=0, grant=0, grant_valid=0, grant_id=0, credit_left=0. Reset dominates all other inputs, including mid-burst.
- Request→grant latency: 1 cycle from IDLE (request sampled at edge k, grant visible after edge k+1).
- Burst handover: the ending ack cycle is the last cycle of the old grant; the new grant is visible the following cycle.
- Beats per burst in mode 1: exactly max(weight_i,1) acks, unless request drops first.
- All outputs are registered; no combinational input→output paths.
- Fairness: with all N requesting, every requester is granted once per N bursts.

## Test plan
- Reset: assert reset 2 cycles with request=all-ones -> grant=0, grant_valid=0, grant_id=0, credit_left=0. First grant lands on requester 0 one cycle after reset deasserts.
- Weighted rotation: N=4, weights {w0..w3}={1,2,3,4}, mode=1, request=4'b1111, grant_ack=1 constant -> grant_id sequence 0,1,1,2,2,2,3,3,3,3,0,… with no idle cycles. credit_left runs 1;2,1;3,2,1;4,3,2,1.
- Plain mode: same stimulus, mode=0 -> grant_id 0,1,2,3,0,… one cycle each, credit_left=1 throughout.
- Zero weight and ack stall: weights {0,2,0,0}, request=4'b0011, ack pattern 1,0,0,1,1 -> requester 0 granted for 1 ack. Requester 1 is then held through the 2 stall cycles and released after 2 acks.
- Request drop mid-burst: weight2=3, requester 2 in burst with credit_left=2, request[2] drops with ack=0, request[3]=1 -> next cycle grant_id=3 and ptr skips over 2. A mode/weight change during the old burst applies only to the requester 3 load.
- Wrap/idle/reset: only request[N-1] high -> repeated bursts to N-1 with fresh credit. Dropping to request=0 gives IDLE the next cycle. Reset asserted mid-burst -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/wrr_credit_arbiter.sv
// Weighted round-robin arbiter with per-grant credit bursts.
// A grantee keeps the shared resource for up to max(weight,1) acknowledged
// beats (or a single beat in plain mode), or until it drops its request.
// Priority then rotates to the requester after the one just served.
// All outputs are registered.
//
// Handshake: grant_ack is a one-cycle strobe meaning "the resource consumed
// one beat from the current grantee this cycle". It is only meaningful while
// grant_valid is high and is ignored otherwise. A burst ends on the cycle that
// carries the last ack (or on the cycle its request is low); the next grant is
// visible from the following cycle, with no idle cycle in between.
module wrr_credit_arbiter #(
    parameter int N   = 8,
    parameter int W   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     request,
    input  logic [N*W-1:0]   weights,
    input  logic             mode,
    input  logic             grant_ack,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic [W-1:0]     credit_left,
    // Debug view of the controller: 0 = IDLE, 1 = BURST, and rotating pointer
    output logic             dbg_state,
    output logic [IDW-1:0]   dbg_ptr
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [W-1:0]   credit_left_q, credit_left_d;

    // Arbitration signals
    logic [IDW-1:0] next_ptr;      // grantee + 1, wrapped mod N
    logic [IDW-1:0] arb_ptr;       // pointer used for this cycle's scan
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [W-1:0]   win_weight;
    logic [W-1:0]   win_credit;
    int             scan_idx;

    // Burst-end detection
    logic           ack_last;
    logic           req_dropped;
    logic           burst_end;

    // Pointer to the requester after the current grantee, wrapping at N-1
    always_comb begin
        next_ptr = '0;
        if (int'(grant_id_q) != N - 1) begin
            next_ptr = grant_id_q + IDW'(1);
        end
    end

    // At a burst end the scan starts after the old grantee; in IDLE it starts at ptr
    assign arb_ptr = (state_q == ST_BURST) ? next_ptr : ptr_q;

    // Circular priority scan: first requester at or after arb_ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N; k++) begin
            scan_idx = (int'(arb_ptr) + k) % N;
            if (!win_found && request[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan_idx);
            end
        end
    end

    // Credit loaded for the winner: weight (zero treated as one) or a single beat
    always_comb begin
        win_weight = weights[int'(win_idx)*W +: W];
        win_credit = W'(1);
        if (mode && (win_weight != '0)) begin
            win_credit = win_weight;
        end
    end

    assign ack_last    = grant_ack && (credit_left_q == W'(1));
    assign req_dropped = !request[grant_id_q];
    assign burst_end   = ack_last || req_dropped;

    // Next-state and next-output logic for the IDLE/BURST controller
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        credit_left_d = credit_left_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d       = ST_BURST;
                    grant_d       = N'(1) << win_idx;
                    grant_valid_d = 1'b1;
                    grant_id_d    = win_idx;
                    credit_left_d = win_credit;
                end
            end

            ST_BURST: begin
                // An ack in the same cycle as a request drop is still counted
                if (grant_ack && (credit_left_q != '0)) begin
                    credit_left_d = credit_left_q - W'(1);
                end
                if (burst_end) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        grant_d       = N'(1) << win_idx;
                        grant_valid_d = 1'b1;
                        grant_id_d    = win_idx;
                        credit_left_d = win_credit;
                    end else begin
                        state_d       = ST_IDLE;
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                        credit_left_d = '0;
                    end
                end
            end

            default: begin
                state_d       = ST_IDLE;
                grant_d       = '0;
                grant_valid_d = 1'b0;
                grant_id_d    = '0;
                credit_left_d = '0;
            end
        endcase
    end

    // State and output registers; reset dominates every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            credit_left_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            credit_left_q <= credit_left_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign credit_left = credit_left_q;
    assign dbg_state   = (state_q == ST_BURST);
    assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_wrr_credit_arbiter.sv
// Directed bench for wrr_credit_arbiter with N=4, W=4.
// Inputs change right after a falling edge; outputs are checked at the
// following falling edge, i.e. after exactly one rising edge.
module tb_wrr_credit_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   request;
    logic [N*W-1:0] weights;
    logic           mode;
    logic           grant_ack;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   credit_left;
    logic           dbg_state;
    logic [IDW-1:0] dbg_ptr;

    int total = 0;
    int bad   = 0;

    wrr_credit_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .weights    (weights),
        .mode       (mode),
        .grant_ack  (grant_ack),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .credit_left(credit_left),
        .dbg_state  (dbg_state),
        .dbg_ptr    (dbg_ptr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, landing on the next falling edge for checking
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output check: valid=0 means idle (all outputs zero)
    task automatic chk_out(input string tag, input logic exp_valid,
                           input int exp_id, input int exp_credit);
        logic [N-1:0] exp_grant;
        exp_grant = exp_valid ? (N'(1) << exp_id) : '0;
        chk({tag, ".grant"},       32'(grant),       32'(exp_grant));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(exp_valid));
        chk({tag, ".grant_id"},    32'(grant_id),    exp_valid ? 32'(exp_id) : 32'd0);
        chk({tag, ".credit_left"}, 32'(credit_left), exp_valid ? 32'(exp_credit) : 32'd0);
        chk({tag, ".state"},       32'(dbg_state),   32'(exp_valid));
    endtask

    int wr_id [11] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
    int wr_cr [11] = '{1, 2, 1, 3, 2, 1, 4, 3, 2, 1, 1};
    int pl_id [5]  = '{1, 2, 3, 0, 1};

    initial begin
        reset     = 1'b1;
        request   = 4'b1111;
        weights   = 16'h4321;   // w3..w0 = 4,3,2,1
        mode      = 1'b1;
        grant_ack = 1'b1;

        // Reset held two cycles with everyone requesting
        tick();
        chk_out("rst1", 1'b0, 0, 0);
        tick();
        chk_out("rst2", 1'b0, 0, 0);
        chk("rst2.ptr", 32'(dbg_ptr), 32'd0);

        // Weighted rotation, ack every cycle
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk_out($sformatf("wrr%0d", i), 1'b1, wr_id[i], wr_cr[i]);
        end

        // Plain mode: one beat per grant
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("plain%0d", i), 1'b1, pl_id[i], 1);
        end

        // Zero weight and ack stall
        reset = 1'b1;
        tick();
        chk_out("rst3", 1'b0, 0, 0);
        reset     = 1'b0;
        mode      = 1'b1;
        weights   = 16'h0020;   // w1 = 2, others 0
        request   = 4'b0011;
        grant_ack = 1'b0;
        tick();
        chk_out("zw.load0", 1'b1, 0, 1);
        grant_ack = 1'b1; tick(); chk_out("zw.ack0", 1'b1, 1, 2);
        grant_ack = 1'b0; tick(); chk_out("zw.stall1", 1'b1, 1, 2);
        grant_ack = 1'b0; tick(); chk_out("zw.stall2", 1'b1, 1, 2);
        grant_ack = 1'b1; tick(); chk_out("zw.ack1", 1'b1, 1, 1);
        grant_ack = 1'b1; tick(); chk_out("zw.ack2", 1'b1, 0, 1);
        chk("zw.ptr", 32'(dbg_ptr), 32'd2);

        // Request drop mid-burst; weight change during burst applies only to next load
        reset = 1'b1;
        tick();
        chk_out("rst4", 1'b0, 0, 0);
        reset     = 1'b0;
        weights   = 16'h2311;   // w2 = 3
        request   = 4'b0100;
        grant_ack = 1'b0;
        tick();
        chk_out("drop.load2", 1'b1, 2, 3);
        weights   = 16'h5711;   // w3 = 5, w2 = 7 (must not reload the burst)
        grant_ack = 1'b1;
        tick();
        chk_out("drop.ack", 1'b1, 2, 2);
        request   = 4'b1000;
        grant_ack = 1'b0;
        tick();
        chk_out("drop.load3", 1'b1, 3, 5);
        chk("drop.ptr", 32'(dbg_ptr), 32'd3);

        // Sole requester N-1: repeated bursts with fresh credit, pointer wraps
        weights   = 16'h2311;   // w3 = 2 for the next load
        grant_ack = 1'b1;
        for (int c = 4; c >= 1; c--) begin
            tick();
            chk_out($sformatf("wrap.c%0d", c), 1'b1, 3, c);
        end
        tick();
        chk_out("wrap.regrant", 1'b1, 3, 2);
        chk("wrap.ptr", 32'(dbg_ptr), 32'd0);

        // Request removed: idle next cycle, ack in idle ignored
        request = 4'b0000;
        tick();
        chk_out("idle1", 1'b0, 0, 0);
        tick();
        chk_out("idle2", 1'b0, 0, 0);

        // Re-request, then reset mid-burst
        request = 4'b1000;
        tick();
        chk_out("rereq", 1'b1, 3, 2);
        reset = 1'b1;
        tick();
        chk_out("rst_mid", 1'b0, 0, 0);
        chk("rst_mid.ptr", 32'(dbg_ptr), 32'd0);
        reset   = 1'b0;
        request = 4'b0000;
        tick();
        chk_out("post_rst", 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
